eth_int_ctrl: RTL and testbench

Interrupt source/mask controller for the Ethernet MAC. It latches single-cycle event pulses from the TX/RX datapath into a sticky, write-1-to-clear source register and gates them with a mask register. It drives the single level-sensitive `intr` line consumed by the Ethernet reset/interrupt interface and monitored by the testbench. A programmable holdoff timer enforces a minimum low time on `intr` between assertions (interrupt coalescing).

---
 rtl/eth_int_ctrl.sv | 135 +++++++++++++
 tb/tb_eth_int_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_int_ctrl.sv
// rtl/eth_int_ctrl.sv - Ethernet MAC interrupt source/mask controller with holdoff
//
// Latches single-cycle datapath event pulses into a sticky write-1-to-clear
// source register. The sources are gated by a mask, and the result drives one
// level-sensitive interrupt line. A programmable holdoff keeps the line low for
// a minimum time between assertions.
//
// Ports:
//   clk    - single clock
//   rst    - asynchronous active-high reset
//   evt    - event pulses, one bit per source (TXB,TXE,RXB,RXE,BUSY,TXC,RXC)
//   addr   - register select: 0 INT_SOURCE, 1 INT_MASK, 2 HOLDOFF, 3 reserved
//   wr/rd  - one-cycle write / read strobes
//   wdata  - write data
//   rdata  - read data, registered, held until the next read
//   rvalid - one-cycle pulse accompanying rdata
//   intr   - registered interrupt request, active-high level
module eth_int_ctrl #(
    parameter int NUM_SRC   = 7,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   evt,
    input  logic [1:0]           addr,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic                 intr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [1:0] A_SOURCE  = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_HOLDOFF = 2'd2;

    logic [NUM_SRC-1:0]   src_q, src_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
    logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
    logic [1:0]           state_q, state_d;
    logic                 intr_q, intr_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;

    logic [NUM_SRC-1:0]   src_clr;
    logic                 pending;
    logic [31:0]          rd_mux;

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:HOLDOFF_W];

    always_comb begin
        // Event set is ORed in last so that a same-cycle event beats the W1C.
        src_clr   = (wr && addr == A_SOURCE) ? wdata[NUM_SRC-1:0] : '0;
        src_d     = (src_q & ~src_clr) | evt;
        mask_d    = (wr && addr == A_MASK) ? wdata[NUM_SRC-1:0] : mask_q;
        holdoff_d = (wr && addr == A_HOLDOFF) ? wdata[HOLDOFF_W-1:0] : holdoff_q;

        pending = |(src_q & mask_q);

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!pending) begin
                    // The holdoff is captured here; later HOLDOFF writes
                    // only apply to the next low period.
                    cnt_d   = holdoff_q;
                    state_d = (holdoff_q != '0) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - HOLDOFF_W'(1);
                if (cnt_q == HOLDOFF_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        intr_d = (state_d == ST_ASSERT);

        // Reads return the register contents from before any same-cycle write.
        case (addr)
            A_SOURCE:  rd_mux = 32'(src_q);
            A_MASK:    rd_mux = 32'(mask_q);
            A_HOLDOFF: rd_mux = 32'(holdoff_q);
            default:   rd_mux = 32'h0;
        endcase
        rdata_d  = rd ? rd_mux : rdata_q;
        rvalid_d = rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            mask_q    <= '0;
            holdoff_q <= '0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            intr_q    <= 1'b0;
            rdata_q   <= 32'h0;
            rvalid_q  <= 1'b0;
        end else begin
            src_q     <= src_d;
            mask_q    <= mask_d;
            holdoff_q <= holdoff_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            intr_q    <= intr_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign intr   = intr_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_eth_int_ctrl.sv
// tb/tb_eth_int_ctrl.sv - self-checking bench for eth_int_ctrl
module tb_eth_int_ctrl;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [6:0]  evt   = 7'h0;
    logic [1:0]  addr  = 2'd0;
    logic        wr    = 1'b0;
    logic        rd    = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        intr;

    always #5 clk = ~clk;

    eth_int_ctrl #(.NUM_SRC(7), .HOLDOFF_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .evt    (evt),
        .addr   (addr),
        .wr     (wr),
        .rd     (rd),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .intr   (intr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. The interrupt line is described by its rules:
    // it follows pending while high, and may only rise once the cycle index
    // has reached (fall cycle + holdoff captured at the fall).
    logic [6:0]  m_src    = 7'h0;
    logic [6:0]  m_mask   = 7'h0;
    logic [15:0] m_hold   = 16'h0;
    logic        m_intr   = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = 32'h0;
    longint      cyc      = 0;
    longint      fall_t   = -100000;
    longint      hlat     = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_src    = 7'h0;
            m_mask   = 7'h0;
            m_hold   = 16'h0;
            m_intr   = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
            fall_t   = -100000;
            hlat     = 0;
        end else begin
            logic        pend;
            logic [31:0] cur;
            pend = |(m_src & m_mask);
            case (addr)
                2'd0:    cur = {25'h0, m_src};
                2'd1:    cur = {25'h0, m_mask};
                2'd2:    cur = {16'h0, m_hold};
                default: cur = 32'h0;
            endcase
            if (rd) m_rdata = cur;
            m_rvalid = rd;
            if (m_intr && !pend) begin
                fall_t = cyc + 1;
                hlat   = longint'(m_hold);
                m_intr = 1'b0;
            end else begin
                m_intr = pend && (m_intr || cyc >= fall_t + hlat);
            end
            m_src = (m_src & ~((wr && addr == 2'd0) ? wdata[6:0] : 7'h0)) | evt;
            if (wr && addr == 2'd1) m_mask = wdata[6:0];
            if (wr && addr == 2'd2) m_hold = wdata[15:0];
            cyc++;
        end
    end

    always @(negedge clk) begin
        check("intr", {31'h0, intr}, {31'h0, m_intr});
        check("rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
        check("rdata", rdata, m_rdata);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic pulse(input logic [6:0] e);
        evt = e;
        @(negedge clk);
        evt = 7'h0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) tick();
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd_reg(2'(a), d);
            check("reset_reg", d, 32'h0);
        end
        check("reset_intr", {31'h0, intr}, 32'h0);

        // Basic latency
        wr_reg(2'd1, 32'h1);
        pulse(7'h01);
        check("lat_n1", {31'h0, intr}, 32'h0);
        tick();
        check("lat_n2", {31'h0, intr}, 32'h1);
        rd_reg(2'd0, d);
        check("src_basic", d, 32'h1);
        wr_reg(2'd0, 32'h1);
        check("clr_n1", {31'h0, intr}, 32'h1);
        tick();
        check("clr_n2", {31'h0, intr}, 32'h0);

        // Masked event, then unmask
        wr_reg(2'd1, 32'h0);
        pulse(7'h04);
        repeat (3) tick();
        check("masked_intr", {31'h0, intr}, 32'h0);
        rd_reg(2'd0, d);
        check("masked_src", d, 32'h4);
        wr_reg(2'd1, 32'h4);
        check("mask_n1", {31'h0, intr}, 32'h0);
        tick();
        check("mask_n2", {31'h0, intr}, 32'h1);

        // Event and W1C on the same bit in the same cycle
        addr = 2'd0; wdata = 32'h4; wr = 1'b1; evt = 7'h04;
        tick();
        wr = 1'b0; evt = 7'h0;
        rd_reg(2'd0, d);
        check("collision_src", d, 32'h4);
        wr_reg(2'd0, 32'h7F);
        repeat (3) tick();

        // Holdoff of 5
        wr_reg(2'd2, 32'h5);
        wr_reg(2'd1, 32'h7F);
        repeat (2) tick();
        pulse(7'h01);
        tick();
        check("hold_rise", {31'h0, intr}, 32'h1);
        wr_reg(2'd0, 32'h1);
        check("hold_w1", {31'h0, intr}, 32'h1);
        tick();
        check("hold_fall", {31'h0, intr}, 32'h0);
        evt = 7'h02;
        tick();
        evt = 7'h0;
        for (int i = 1; i <= 5; i++) begin
            check("hold_low", {31'h0, intr}, 32'h0);
            tick();
        end
        check("hold_reassert", {31'h0, intr}, 32'h1);

        // Holdoff of 0: written during the running holdoff
        wr_reg(2'd0, 32'h7F);
        wr_reg(2'd2, 32'h0);
        repeat (8) tick();
        pulse(7'h01);
        tick();
        check("h0_rise", {31'h0, intr}, 32'h1);
        wr_reg(2'd0, 32'h1);
        evt = 7'h01;
        tick();
        evt = 7'h0;
        check("h0_fall", {31'h0, intr}, 32'h0);
        tick();
        check("h0_reassert", {31'h0, intr}, 32'h1);

        // Register access
        wr_reg(2'd1, 32'hFFFF_FFFF);
        rd_reg(2'd1, d);
        check("mask_width", d, 32'h7F);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd3, d);
        check("addr3_read", d, 32'h0);
        wr_reg(2'd2, 32'hABCD_1234);
        rd_reg(2'd2, d);
        check("holdoff_width", d, 32'h1234);
        wr_reg(2'd2, 32'h0);
        addr = 2'd1; wdata = 32'h15; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("rdwr_old", rdata, 32'h7F);
        rd_reg(2'd1, d);
        check("rdwr_new", d, 32'h15);

        // Asynchronous reset while asserted
        pulse(7'h01);
        tick();
        check("pre_rst_intr", {31'h0, intr}, 32'h1);
        addr = 2'd1; rd = 1'b1;
        tick();
        rd = 1'b0;
        check("pre_rst_rvalid", {31'h0, rvalid}, 32'h1);
        check("pre_rst_rdata", rdata, 32'h15);
        #1 rst = 1'b1;
        #1;
        check("async_intr", {31'h0, intr}, 32'h0);
        check("async_rvalid", {31'h0, rvalid}, 32'h0);
        check("async_rdata", rdata, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd_reg(2'(a), d);
            check("post_rst_reg", d, 32'h0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            evt  = ($urandom_range(0, 5) == 0) ? 7'($urandom) : 7'h0;
            addr = 2'($urandom);
            wr   = ($urandom_range(0, 4) == 0);
            rd   = ($urandom_range(0, 2) == 0);
            wdata = (addr == 2'd2) ? 32'($urandom_range(0, 7)) : $urandom;
            tick();
        end
        evt = 7'h0; wr = 1'b0; rd = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
